// File: rtl/mult_accumulator_pkg.sv
// Shared definitions for the multiply-accumulate "accumulate" stage.
// Provides the default datapath widths and the controller state encoding.
package mult_accumulator_pkg;

    localparam int unsigned P_W_DEF   = 8;   // multiplier product width
    localparam int unsigned ACC_W_DEF = 12;  // accumulator width
    localparam int unsigned CNT_W_DEF = 4;   // product-count width

    // Controller states; 2'b11 is unused and recovers to ST_IDLE.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ACCUM = 2'b01,
        ST_FIN   = 2'b10
    } state_e;

endpackage

// File: rtl/acc_ripple_adder.sv
// W-bit ripple-carry adder built from full_Adder cells, carry-in tied low.
// Ports: a_i, b_i - W-bit addends; sum_o - W-bit sum (mod 2^W);
//        cout_o - carry out of the MSB, feeds the accumulator overflow flag.
module acc_ripple_adder #(
    parameter int unsigned W = 12
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] sum_o,
    output logic         cout_o
);

    logic [W:0] carry;

    assign carry[0] = 1'b0;

    for (genvar i = 0; i < W; i++) begin : g_bit
        full_Adder u_fa (
            .a    (a_i[i]),
            .b    (b_i[i]),
            .cin  (carry[i]),
            .sum  (sum_o[i]),
            .cout (carry[i+1])
        );
    end

    assign cout_o = carry[W];

endmodule

// File: rtl/full_Adder.sv
// Single-bit full adder cell used to build ripple-carry adders.
// Ports: a, b, cin - addend bits and carry in; sum, cout - result and carry out.
module full_Adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/mult_accumulator.sv
// Accumulates N successive multiplier products into a wide sum.
// Ports:
//   CLK, RST      - rising-edge clock, asynchronous active-high reset
//   START, N      - start a run of N products (N latched in IDLE on START)
//   P, P_VALID    - product from the multiplier and its valid strobe
//   P_READY       - product accepted on any edge where P_VALID is also high
//   ACC, OVF      - running/final sum and sticky carry-out for this run
//   BUSY, DONE    - run in progress; one-cycle completion pulse
module mult_accumulator
    import mult_accumulator_pkg::*;
#(
    parameter int unsigned P_W   = P_W_DEF,
    parameter int unsigned ACC_W = ACC_W_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [CNT_W-1:0] N,
    input  logic [P_W-1:0]   P,
    input  logic             P_VALID,
    output logic             P_READY,
    output logic [ACC_W-1:0] ACC,
    output logic             BUSY,
    output logic             DONE,
    output logic             OVF
);

    state_e           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;

    logic [ACC_W-1:0] add_sum;
    logic             add_cout;

    // Adder always sees the current sum plus the zero-extended product.
    acc_ripple_adder #(
        .W (ACC_W)
    ) u_adder (
        .a_i    (acc_q),
        .b_i    (ACC_W'(P)),
        .sum_o  (add_sum),
        .cout_o (add_cout)
    );

    // State and datapath registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;

        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    acc_d = '0;
                    ovf_d = 1'b0;
                    if (N != '0) begin
                        cnt_d   = N;
                        state_d = ST_ACCUM;
                    end else begin
                        // Zero-length run goes straight to completion.
                        state_d = ST_FIN;
                    end
                end
            end
            ST_ACCUM: begin
                // P_READY is high throughout ACCUM, so P_VALID alone marks a transfer.
                if (P_VALID) begin
                    acc_d = add_sum;
                    ovf_d = ovf_q | add_cout;
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = ST_FIN;
                    end
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Handshake and status decoded purely from the state register.
    assign P_READY = (state_q == ST_ACCUM);
    assign BUSY    = (state_q == ST_ACCUM);
    assign DONE    = (state_q == ST_FIN);
    assign ACC     = acc_q;
    assign OVF     = ovf_q;

endmodule

// File: tb/tb_mult_accumulator.sv
// Self-checking bench: two accumulators (12-bit and 8-bit) share one stimulus
// stream; each is compared to a sum-of-products reference after every edge.
module tb_mult_accumulator;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] n_in;
    logic [7:0] p;
    logic       p_valid;

    logic        rdy_a, busy_a, done_a, ovf_a;
    logic [11:0] acc_a;
    logic        rdy_b, busy_b, done_b, ovf_b;
    logic [7:0]  acc_b;

    int n_cmp = 0;
    int n_err = 0;

    int prod_q[$];
    int gap_q[$];

    always #5 clk = ~clk;

    mult_accumulator #(.P_W(8), .ACC_W(12), .CNT_W(4)) u_dut_a (
        .CLK(clk), .RST(rst), .START(start), .N(n_in), .P(p), .P_VALID(p_valid),
        .P_READY(rdy_a), .ACC(acc_a), .BUSY(busy_a), .DONE(done_a), .OVF(ovf_a)
    );

    mult_accumulator #(.P_W(8), .ACC_W(8), .CNT_W(4)) u_dut_b (
        .CLK(clk), .RST(rst), .START(start), .N(n_in), .P(p), .P_VALID(p_valid),
        .P_READY(rdy_b), .ACC(acc_b), .BUSY(busy_b), .DONE(done_b), .OVF(ovf_b)
    );

    task automatic check(input string tag, input longint got, input longint exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // Compare both DUTs against the reference sum and expected phase.
    task automatic check_all(input string tag, input longint sum, input bit busy, input bit done);
        check({tag, ".acc12"}, longint'(acc_a), sum % 4096);
        check({tag, ".ovf12"}, longint'(ovf_a), longint'(sum >= 4096));
        check({tag, ".acc8"},  longint'(acc_b), sum % 256);
        check({tag, ".ovf8"},  longint'(ovf_b), longint'(sum >= 256));
        check({tag, ".busy"},  longint'(busy_a), longint'(busy));
        check({tag, ".ready"}, longint'(rdy_a),  longint'(busy));
        check({tag, ".done"},  longint'(done_a), longint'(done));
        check({tag, ".busy8"}, longint'(busy_b), longint'(busy));
        check({tag, ".done8"}, longint'(done_b), longint'(done));
    endtask

    // One complete run using prod_q (products) and gap_q (idle cycles before each).
    task automatic do_run(input string tag, input int n);
        longint sum = 0;
        int     sent = 0;
        int     gi = 0;
        int     budget = 0;

        start   = 1'b1;
        n_in    = 4'(n);
        p_valid = 1'($urandom_range(0, 1));
        p       = 8'($urandom);
        @(posedge clk); #1;
        start = 1'b0;
        check_all({tag, ".start"}, 0, n != 0, n == 0);

        while (sent < n && budget < 500) begin
            if (gi < gap_q[sent]) begin
                p_valid = 1'b0;
                p       = 8'($urandom);
                gi++;
            end else begin
                p_valid = 1'b1;
                p       = 8'(prod_q[sent]);
            end
            // START and N are noise while a run is in progress.
            start = 1'($urandom_range(0, 1));
            n_in  = 4'($urandom);
            @(posedge clk); #1;
            budget++;
            if (p_valid) begin
                sum += longint'(p);
                sent++;
                gi = 0;
            end
            check_all({tag, ".accum"}, sum, sent < n, sent == n);
        end
        if (sent < n) check({tag, ".budget"}, sent, n);

        // Completion cycle: START and a valid product must both be ignored.
        start   = 1'b1;
        n_in    = 4'($urandom_range(1, 15));
        p_valid = 1'b1;
        p       = 8'($urandom_range(1, 255));
        @(posedge clk); #1;
        start = 1'b0;
        check_all({tag, ".idle"}, sum, 1'b0, 1'b0);

        // P_VALID in IDLE leaves the result untouched.
        p_valid = 1'b1;
        p       = 8'($urandom_range(1, 255));
        @(posedge clk); #1;
        p_valid = 1'b0;
        check_all({tag, ".idle_pv"}, sum, 1'b0, 1'b0);
    endtask

    task automatic load(input int n, input int prods[$], input int gaps[$]);
        prod_q = prods;
        gap_q  = gaps;
        if (prod_q.size() != n || gap_q.size() != n) begin
            $display("FAIL load: table size %0d expected %0d", prod_q.size(), n);
            n_err++;
        end
    endtask

    initial begin
        int na, nb;
        int np;

        rst = 1'b1; start = 1'b0; n_in = '0; p = '0; p_valid = 1'b0;
        #3;
        check_all("reset", 0, 1'b0, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Reset mid-run clears the partial sum without a clock edge.
        start = 1'b1; n_in = 4'd3;
        @(posedge clk); #1;
        start = 1'b0; p_valid = 1'b1; p = 8'h10;
        @(posedge clk); #1;
        p_valid = 1'b0;
        check("midrun.partial", longint'(acc_a), 16);
        #2 rst = 1'b1;
        #1;
        check_all("midrun.async", 0, 1'b0, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        check_all("midrun.after", 0, 1'b0, 1'b0);

        load(3, '{6, 15, 225}, '{0, 0, 0});
        do_run("basic", 3);

        load(2, '{100, 50}, '{0, 3});
        do_run("stall", 2);

        prod_q = {}; gap_q = {};
        for (int i = 0; i < 15; i++) begin
            prod_q.push_back(225);
            gap_q.push_back(0);
        end
        do_run("maxload", 15);

        load(2, '{200, 100}, '{0, 0});
        do_run("ovf", 2);

        prod_q = {}; gap_q = {};
        do_run("zero", 0);

        for (int r = 0; r < 20; r++) begin
            np = $urandom_range(0, 15);
            prod_q = {}; gap_q = {};
            for (int i = 0; i < np; i++) begin
                na = $urandom_range(0, 15);
                nb = $urandom_range(0, 15);
                prod_q.push_back(na * nb);
                gap_q.push_back($urandom_range(0, 2));
            end
            do_run("rand", np);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
